// File: rtl/ctrl_decode_pipe.sv
// Instruction decode stage with a 2-entry skid buffer toward EX.
// Decodes RV32I control signals from the fetched word, holds up to two decoded
// entries (main + skid), and counts illegal instructions handed downstream.
// Optional feature: define CTRL_DECODE_MEXT_EN to decode RV32M (funct7 = 0000001).
module ctrl_decode_pipe #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_instr,
  input  logic [PC_W-1:0]  i_pc,
  input  logic             i_vld,
  output logic             o_rdy,
  input  logic             i_rdy,
  input  logic             i_flush,
  output logic             o_vld,
  output logic [31:0]      o_instr,
  output logic [PC_W-1:0]  o_pc,
  output logic             o_rd_wren,
  output logic             o_mem_wren,
  output logic             o_br_un,
  output logic             o_lui_sel,
  output logic             o_isload,
  output logic             o_insn_vld,
  output logic [1:0]       o_opa_sel,
  output logic [1:0]       o_opb_sel,
  output logic [1:0]       o_wb_sel,
  output logic [4:0]       o_alu_op,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  // Opcodes, instr[6:2]
  localparam logic [4:0] OpLoad   = 5'b00000;
  localparam logic [4:0] OpImm    = 5'b00100;
  localparam logic [4:0] OpAuipc  = 5'b00101;
  localparam logic [4:0] OpStore  = 5'b01000;
  localparam logic [4:0] OpReg    = 5'b01100;
  localparam logic [4:0] OpLui    = 5'b01101;
  localparam logic [4:0] OpBranch = 5'b11000;
  localparam logic [4:0] OpJalr   = 5'b11001;
  localparam logic [4:0] OpJal    = 5'b11011;

  localparam logic [4:0] AluAdd  = 5'd0;
  localparam logic [4:0] AluSub  = 5'd1;
  localparam logic [4:0] AluSll  = 5'd2;
  localparam logic [4:0] AluSlt  = 5'd3;
  localparam logic [4:0] AluSltu = 5'd4;
  localparam logic [4:0] AluXor  = 5'd5;
  localparam logic [4:0] AluSrl  = 5'd6;
  localparam logic [4:0] AluSra  = 5'd7;
  localparam logic [4:0] AluOr   = 5'd8;
  localparam logic [4:0] AluAnd  = 5'd9;

  localparam logic [1:0] SelReg = 2'b00;
  localparam logic [1:0] SelPc  = 2'b11;
  localparam logic [1:0] SelImm = 2'b11;
  localparam logic [1:0] WbLsu  = 2'b00;
  localparam logic [1:0] WbAlu  = 2'b01;
  localparam logic [1:0] WbPc4  = 2'b10;

  typedef struct packed {
    logic       rd_wren;
    logic       mem_wren;
    logic       br_un;
    logic       lui_sel;
    logic       isload;
    logic       insn_vld;
    logic [1:0] opa_sel;
    logic [1:0] opb_sel;
    logic [1:0] wb_sel;
    logic [4:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    ctrl_t           ctrl;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q, state_d;
  logic             rdy_q, rdy_d;
  logic             vld;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            dec_c;
  logic             legal;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             acc, deq;

  // funct3 to ALU op; alt selects SUB/SRA where the encoding allows it
  function automatic logic [4:0] alu_of_f3(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'd0:    op = alt ? AluSub : AluAdd;
      3'd1:    op = AluSll;
      3'd2:    op = AluSlt;
      3'd3:    op = AluSltu;
      3'd4:    op = AluXor;
      3'd5:    op = alt ? AluSra : AluSrl;
      3'd6:    op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];
  assign acc    = i_vld && rdy_q;
  assign deq    = vld && i_rdy;

  // Combinational decode of the incoming word; illegal words clear every control
  always_comb begin
    dec_c = '0;
    legal = 1'b0;
    case (i_instr[6:2])
      OpReg: begin
        dec_c.rd_wren = 1'b1;
        dec_c.wb_sel  = WbAlu;
        dec_c.opb_sel = SelReg;
        if (funct7 == 7'b0000000) begin
          legal        = 1'b1;
          dec_c.alu_op = alu_of_f3(funct3, 1'b0);
        end else if (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5)) begin
          legal        = 1'b1;
          dec_c.alu_op = alu_of_f3(funct3, 1'b1);
`ifdef CTRL_DECODE_MEXT_EN
        end else if (funct7 == 7'b0000001) begin
          legal        = 1'b1;
          dec_c.alu_op = 5'd10 + {2'b00, funct3};
`endif
        end
      end
      OpImm: begin
        legal         = 1'b1;
        dec_c.rd_wren = 1'b1;
        dec_c.opb_sel = SelImm;
        dec_c.wb_sel  = WbAlu;
        dec_c.alu_op  = alu_of_f3(funct3, (funct3 == 3'd5) && i_instr[30]);
      end
      OpLoad: begin
        legal         = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
        dec_c.rd_wren = 1'b1;
        dec_c.isload  = 1'b1;
        dec_c.opb_sel = SelImm;
        dec_c.wb_sel  = WbLsu;
      end
      OpStore: begin
        legal          = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2);
        dec_c.mem_wren = 1'b1;
        dec_c.opb_sel  = SelImm;
      end
      OpBranch: begin
        legal         = (funct3 != 3'd2) && (funct3 != 3'd3);
        dec_c.opa_sel = SelPc;
        dec_c.opb_sel = SelImm;
        dec_c.br_un   = !funct3[2] || !funct3[1];
      end
      OpLui: begin
        legal         = 1'b1;
        dec_c.rd_wren = 1'b1;
        dec_c.lui_sel = 1'b1;
        dec_c.opb_sel = SelImm;
        dec_c.wb_sel  = WbAlu;
      end
      OpAuipc: begin
        legal         = 1'b1;
        dec_c.rd_wren = 1'b1;
        dec_c.opa_sel = SelPc;
        dec_c.opb_sel = SelImm;
        dec_c.wb_sel  = WbAlu;
      end
      OpJal: begin
        legal         = 1'b1;
        dec_c.rd_wren = 1'b1;
        dec_c.opa_sel = SelPc;
        dec_c.opb_sel = SelImm;
        dec_c.wb_sel  = WbPc4;
      end
      OpJalr: begin
        legal         = 1'b1;
        dec_c.rd_wren = 1'b1;
        dec_c.opa_sel = SelReg;
        dec_c.opb_sel = SelImm;
        dec_c.wb_sel  = WbPc4;
      end
      default: legal = 1'b0;
    endcase
    if (legal) begin
      dec_c.insn_vld = 1'b1;
    end else begin
      dec_c = '0;
    end
  end

  // Skid FSM state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Skid FSM next state; flush wins over every other transition
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: if (acc) state_d = StOne;
        StOne: begin
          if (acc && !deq)      state_d = StTwo;
          else if (deq && !acc) state_d = StEmpty;
        end
        StTwo:   if (deq) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  // Skid FSM outputs: valid from current state, ready registered from next state
  always_comb begin
    vld   = (state_q != StEmpty);
    rdy_d = (state_d != StTwo);
  end

  // Entry movement: new words land in main (or skid when main is stalled)
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (!i_flush) begin
      case (state_q)
        StEmpty: if (acc) main_d = '{instr: i_instr, pc: i_pc, ctrl: dec_c};
        StOne: begin
          if (acc && deq)  main_d = '{instr: i_instr, pc: i_pc, ctrl: dec_c};
          else if (acc)    skid_d = '{instr: i_instr, pc: i_pc, ctrl: dec_c};
        end
        StTwo:   if (deq) main_d = skid_q;
        default: main_d = main_q;
      endcase
    end
  end

  // Saturating count of illegal words consumed downstream
  always_comb begin
    cnt_d = cnt_q;
    if (deq && !main_q.ctrl.insn_vld && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Datapath and counter registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rdy_q  <= 1'b1;
      main_q <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      rdy_q  <= rdy_d;
      main_q <= main_d;
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_rdy         = rdy_q;
  assign o_vld         = vld;
  assign o_instr       = main_q.instr;
  assign o_pc          = main_q.pc;
  assign o_rd_wren     = main_q.ctrl.rd_wren;
  assign o_mem_wren    = main_q.ctrl.mem_wren;
  assign o_br_un       = main_q.ctrl.br_un;
  assign o_lui_sel     = main_q.ctrl.lui_sel;
  assign o_isload      = main_q.ctrl.isload;
  assign o_insn_vld    = main_q.ctrl.insn_vld;
  assign o_opa_sel     = main_q.ctrl.opa_sel;
  assign o_opb_sel     = main_q.ctrl.opb_sel;
  assign o_wb_sel      = main_q.ctrl.wb_sel;
  assign o_alu_op      = main_q.ctrl.alu_op;
  assign o_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed scoreboard bench for ctrl_decode_pipe.
module tb_ctrl_decode_pipe;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 8;

  // Expected control vector layout:
  // {rd_wren, mem_wren, br_un, lui_sel, isload, insn_vld, opa[1:0], opb[1:0], wb[1:0], alu[4:0]}
  localparam logic [16:0] C_ADD  = {6'b100001, 2'b00, 2'b00, 2'b01, 5'd0};
  localparam logic [16:0] C_SUB  = {6'b100001, 2'b00, 2'b00, 2'b01, 5'd1};
  localparam logic [16:0] C_LW   = {6'b100011, 2'b00, 2'b11, 2'b00, 5'd0};
  localparam logic [16:0] C_BNE  = {6'b001001, 2'b11, 2'b11, 2'b00, 5'd0};
  localparam logic [16:0] C_BGEU = {6'b000001, 2'b11, 2'b11, 2'b00, 5'd0};
  localparam logic [16:0] C_ILL  = 17'd0;
  localparam logic [16:0] C_LUI  = {6'b100101, 2'b00, 2'b11, 2'b01, 5'd0};
  localparam logic [16:0] C_SRAI = {6'b100001, 2'b00, 2'b11, 2'b01, 5'd7};
  localparam logic [16:0] C_SW   = {6'b010001, 2'b00, 2'b11, 2'b00, 5'd0};
  localparam logic [16:0] C_JAL  = {6'b100001, 2'b11, 2'b11, 2'b10, 5'd0};
`ifdef CTRL_DECODE_MEXT_EN
  localparam logic [16:0] C_MUL  = {6'b100001, 2'b00, 2'b00, 2'b01, 5'd10};
`else
  localparam logic [16:0] C_MUL  = 17'd0;
`endif

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_BNE  = 32'h00209063;
  localparam logic [31:0] I_BGEU = 32'h0020F063;
  localparam logic [31:0] I_BILL = 32'h0020A063;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_SRAI = 32'h4010D093;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_ONES = 32'hFFFFFFFF;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic [31:0]      i_instr = '0;
  logic [PC_W-1:0]  i_pc = '0;
  logic             i_vld = 1'b0;
  logic             o_rdy;
  logic             i_rdy = 1'b1;
  logic             i_flush = 1'b0;
  logic             o_vld;
  logic [31:0]      o_instr;
  logic [PC_W-1:0]  o_pc;
  logic             o_rd_wren, o_mem_wren, o_br_un, o_lui_sel, o_isload, o_insn_vld;
  logic [1:0]       o_opa_sel, o_opb_sel, o_wb_sel;
  logic [4:0]       o_alu_op;
  logic [CNT_W-1:0] o_illegal_cnt;
  logic [16:0]      dut_ctrl;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [16:0] ctrl;
  } sb_t;

  sb_t         sb[$];
  logic [16:0] drv_ctrl = '0;
  logic [31:0] pc_ctr = 32'h1000;
  int          exp_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  ctrl_decode_pipe #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_instr(i_instr), .i_pc(i_pc), .i_vld(i_vld),
    .o_rdy(o_rdy), .i_rdy(i_rdy), .i_flush(i_flush), .o_vld(o_vld), .o_instr(o_instr),
    .o_pc(o_pc), .o_rd_wren(o_rd_wren), .o_mem_wren(o_mem_wren), .o_br_un(o_br_un),
    .o_lui_sel(o_lui_sel), .o_isload(o_isload), .o_insn_vld(o_insn_vld),
    .o_opa_sel(o_opa_sel), .o_opb_sel(o_opb_sel), .o_wb_sel(o_wb_sel),
    .o_alu_op(o_alu_op), .o_illegal_cnt(o_illegal_cnt)
  );

  assign dut_ctrl = {o_rd_wren, o_mem_wren, o_br_un, o_lui_sel, o_isload, o_insn_vld,
                     o_opa_sel, o_opb_sel, o_wb_sel, o_alu_op};

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare on each downstream handshake, record each upstream acceptance
  always @(negedge i_clk) begin
    if (i_reset) begin
      check("rst_vld", o_vld, 0);
      check("rst_rdy", o_rdy, 1);
      check("rst_cnt", o_illegal_cnt, 0);
      check("rst_data", {o_instr, o_pc, 15'd0, dut_ctrl}, 0);
      sb.delete();
      exp_cnt = 0;
    end else begin
      check("illegal_cnt", o_illegal_cnt, exp_cnt);
      if (o_vld && i_rdy) begin
        check("sb_has_entry", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          sb_t e;
          e = sb.pop_front();
          check("out_instr", o_instr, e.instr);
          check("out_pc", o_pc, e.pc);
          check("out_ctrl", dut_ctrl, e.ctrl);
          if (e.ctrl[11] == 1'b0 && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
        end
      end
      if (i_flush) begin
        sb.delete();
      end else if (i_vld && o_rdy) begin
        sb.push_back('{instr: i_instr, pc: i_pc, ctrl: drv_ctrl});
      end
    end
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [16:0] c);
    i_instr  = ins;
    i_pc     = pc_ctr;
    pc_ctr   = pc_ctr + 32'd4;
    drv_ctrl = c;
    i_vld    = 1'b1;
  endtask

  // Present one word and hold it until accepted (bounded)
  task automatic send(input logic [31:0] ins, input logic [16:0] c, input bit rnd);
    int k;
    drive(ins, c);
    k = 0;
    while (!o_rdy && k < 50) begin
      if (rnd) i_rdy = 1'($urandom_range(0, 1));
      cyc();
      k++;
    end
    check("send_accept", o_rdy, 1);
    if (rnd) i_rdy = 1'($urandom_range(0, 1));
    cyc();
    i_vld = 1'b0;
  endtask

  task automatic drain();
    int k;
    i_vld = 1'b0;
    i_rdy = 1'b1;
    k = 0;
    while ((o_vld || sb.size() != 0) && k < 100) begin
      cyc();
      k++;
    end
    check("drain_vld", o_vld, 0);
    check("drain_sb", sb.size(), 0);
  endtask

  logic [31:0] tbl_i [12];
  logic [16:0] tbl_c [12];

  initial begin
    int n_ill;
    tbl_i = '{I_SUB, I_LW, I_BNE, I_BGEU, I_BILL, I_LUI, I_SRAI, I_SW, I_JAL, I_MUL, I_ONES,
              I_ADD};
    tbl_c = '{C_SUB, C_LW, C_BNE, C_BGEU, C_ILL, C_LUI, C_SRAI, C_SW, C_JAL, C_MUL, C_ILL,
              C_ADD};

    // Reset
    repeat (3) cyc();
    i_reset = 1'b0;

    // Single add: one-cycle latency
    drive(I_ADD, C_ADD);
    cyc();
    i_vld = 1'b0;
    check("add_vld", o_vld, 1);
    check("add_ctrl", dut_ctrl, C_ADD);
    drain();

    // Backpressure: two accepted, third held, then in-order delivery
    i_rdy = 1'b0;
    drive(I_ADD, C_ADD);
    cyc();
    check("bp_rdy1", o_rdy, 1);
    drive(I_SUB, C_SUB);
    cyc();
    check("bp_rdy2", o_rdy, 0);
    drive(I_LW, C_LW);
    cyc();
    check("bp_rdy3", o_rdy, 0);
    check("bp_oldest", o_instr, I_ADD);
    i_rdy = 1'b1;
    cyc();
    check("bp_rdy4", o_rdy, 1);
    check("bp_second", o_instr, I_SUB);
    cyc();
    i_vld = 1'b0;
    check("bp_third", o_instr, I_LW);
    drain();

    // Branch decode and illegal counting
    send(I_BNE, C_BNE, 1'b0);
    check("bne_brun", o_br_un, 1);
    check("bne_opa", o_opa_sel, 2'b11);
    drain();
    send(I_BGEU, C_BGEU, 1'b0);
    check("bgeu_brun", o_br_un, 0);
    drain();
    send(I_BILL, C_ILL, 1'b0);
    check("bill_vld", o_insn_vld, 0);
    check("bill_cnt0", o_illegal_cnt, 0);
    cyc();
    check("bill_cnt1", o_illegal_cnt, 1);
    drain();

    // Decode table under random downstream backpressure
    n_ill = 0;
    for (int i = 0; i < 12; i++) begin
      send(tbl_i[i], tbl_c[i], 1'b1);
      if (tbl_c[i][11] == 1'b0) n_ill++;
    end
    drain();
    check("tbl_cnt", o_illegal_cnt, 1 + n_ill);

    // RV32M word, legal only with the extension enabled
    send(I_MUL, C_MUL, 1'b0);
    check("mul_ctrl", dut_ctrl, C_MUL);
    drain();

    // Flush while full with a same-cycle valid word
    i_rdy = 1'b0;
    drive(I_ADD, C_ADD);
    cyc();
    drive(I_SUB, C_SUB);
    cyc();
    check("fl_full", o_rdy, 0);
    drive(I_LUI, C_LUI);
    i_flush = 1'b1;
    cyc();
    i_flush = 1'b0;
    i_vld = 1'b0;
    check("fl_vld", o_vld, 0);
    check("fl_rdy", o_rdy, 1);
    i_rdy = 1'b1;
    cyc();
    check("fl_vld2", o_vld, 0);
    send(I_SRAI, C_SRAI, 1'b0);
    check("fl_next", o_instr, I_SRAI);
    drain();

    // Reset asserted with entries buffered
    i_rdy = 1'b0;
    drive(I_ADD, C_ADD);
    cyc();
    drive(I_JAL, C_JAL);
    cyc();
    i_vld = 1'b0;
    #2 i_reset = 1'b1;
    #1;
    check("mr_vld", o_vld, 0);
    check("mr_rdy", o_rdy, 1);
    check("mr_instr", o_instr, 0);
    check("mr_cnt", o_illegal_cnt, 0);
    cyc();
    i_reset = 1'b0;
    i_rdy = 1'b1;
    drive(I_SW, C_SW);
    cyc();
    i_vld = 1'b0;
    check("mr_first_vld", o_vld, 1);
    check("mr_first", o_instr, I_SW);
    drain();

    // Counter saturation
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      drive(I_ONES, C_ILL);
      cyc();
    end
    drain();
    check("sat_cnt", o_illegal_cnt, {CNT_W{1'b1}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end of the sequence");
    $fatal(1, "timeout");
  end

endmodule
